// File: rtl/ik_iter_ctrl.sv
// ik_iter_ctrl: iteration sequencer for the ik_swift solver datapath.
// Build macro THETA_WRAP_EN: fold each updated angle back into [-PI, PI].
//
// state | meaning
// IDLE  | solver held in reset, host may load theta, waits for start
// KICK  | one-cycle solver reset pulse, clears latency counter
// WAIT  | solver running, counts SOLVER_LATENCY cycles to valid delta
// APPLY | folds delta_j into theta[j], one joint per cycle
// CHECK | bumps iter_count, decides converged / cap / next iteration
// DONE  | result frozen, done held, host may reload or restart
module ik_iter_ctrl #(
  parameter int NJ             = 6,
  parameter int W              = 36,
  parameter int SOLVER_LATENCY = 64,
  parameter int MAX_ITER       = 32,
  parameter int ITER_W         = 6,
  parameter int EPS            = 66
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              init_valid,
  input  logic [2:0]        init_joint,
  input  logic [W-1:0]      init_theta,
  input  logic [NJ*W-1:0]   delta_in,
  output logic              solver_rst,
  output logic [NJ*W-1:0]   theta_out,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam int LAT_W = $clog2(SOLVER_LATENCY + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(SOLVER_LATENCY - 1);
  localparam logic [2:0]        JDX_LAST = 3'(NJ - 1);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);
  localparam logic signed [W:0] SUM_MAX  = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SUM_MIN  = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [W:0] EPS_X    = (W+1)'(EPS);
`ifdef THETA_WRAP_EN
  localparam logic signed [W-1:0] PI     = W'(205887);
  localparam logic signed [W-1:0] NEG_PI = -PI;
  localparam logic signed [W-1:0] TWO_PI = W'(411775);
`endif

  typedef enum logic [2:0] {IDLE, KICK, WAIT, APPLY, CHECK, DONE} state_t;

  state_t state, state_nx;

  logic signed [W-1:0] theta [NJ];
  logic [LAT_W-1:0]    lat_cnt;
  logic [2:0]          jdx;
  logic                small_all;
  logic [ITER_W-1:0]   iter_inc;

  logic signed [W-1:0] d_sel, th_sel, th_new;
  logic signed [W:0]   sum_ext, d_ext, d_abs;
  logic                d_small;

  assign iter_inc   = iter_count + ITER_W'(1);
  assign solver_rst = (state == IDLE) || (state == KICK) || (state == DONE);
  assign busy       = (state == KICK) || (state == WAIT) || (state == APPLY) || (state == CHECK);
  assign done       = (state == DONE);

  always_comb begin
    theta_out = '0;
    for (int i = 0; i < NJ; i++) theta_out[i*W +: W] = theta[i];
  end

  // Update path for the joint selected by jdx: widened add, clamp, optional wrap.
  always_comb begin
    d_sel  = '0;
    th_sel = '0;
    for (int i = 0; i < NJ; i++) begin
      if (jdx == 3'(i)) begin
        d_sel  = delta_in[i*W +: W];
        th_sel = theta[i];
      end
    end
    sum_ext = {th_sel[W-1], th_sel} + {d_sel[W-1], d_sel};
    if (sum_ext > SUM_MAX)      th_new = SUM_MAX[W-1:0];
    else if (sum_ext < SUM_MIN) th_new = SUM_MIN[W-1:0];
    else                        th_new = sum_ext[W-1:0];
`ifdef THETA_WRAP_EN
    if (th_new > PI)           th_new = th_new - TWO_PI;
    else if (th_new < NEG_PI)  th_new = th_new + TWO_PI;
`endif
    d_ext   = {d_sel[W-1], d_sel};
    d_abs   = (d_ext < 0) ? -d_ext : d_ext;
    d_small = (d_abs < EPS_X);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = KICK;
      KICK:       state_nx = WAIT;
      WAIT:       if (lat_cnt == LAT_LAST) state_nx = APPLY;
      APPLY:      if (jdx == JDX_LAST) state_nx = CHECK;
      CHECK: begin
        if (small_all || (iter_inc == ITER_CAP)) state_nx = DONE;
        else                                     state_nx = KICK;
      end
      default:    state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Abort freezes every datapath register except converged, which it clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NJ; i++) theta[i] <= '0;
      lat_cnt    <= '0;
      jdx        <= '0;
      small_all  <= 1'b0;
      iter_count <= '0;
      converged  <= 1'b0;
    end else if (abort) begin
      converged <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (init_valid) begin
            for (int i = 0; i < NJ; i++)
              if (init_joint == 3'(i)) theta[i] <= init_theta;
          end
          if (start) begin
            iter_count <= '0;
            converged  <= 1'b0;
          end
        end
        KICK: lat_cnt <= '0;
        WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_cnt == LAT_LAST) begin
            jdx       <= '0;
            small_all <= 1'b1;
          end
        end
        APPLY: begin
          for (int i = 0; i < NJ; i++)
            if (jdx == 3'(i)) theta[i] <= th_new;
          small_all <= small_all & d_small;
          jdx       <= jdx + 3'd1;
        end
        CHECK: begin
          iter_count <= iter_inc;
          converged  <= small_all;
        end
        default: ;
      endcase
    end
  end

endmodule
